// File: rtl/store_unit_if.sv
// Store-port bundle between the core, the store unit and data memory.
// The unit sits on the slave modport; the core/memory side uses master.
interface store_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_done;
  logic        st_err;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  // Core request: transfer on the rising edge where st_valid && st_ready.
  // Memory write: mem_req and its payload are held until mem_ack is sampled high.
  modport slave (
    input  st_valid, st_addr, st_data, st_funct3, mem_ack,
    output st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output st_valid, st_addr, st_data, st_funct3, mem_ack,
    input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_unit.sv
// Store unit: captures one SB/SH/SW request, steers it onto byte lanes and holds a memory
// write until ack or timeout. Define STORE_MISALIGN_TRAP_EN to reject misaligned SH/SW.
module store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  store_unit_if.slave       io_bus,
  output logic              o_state
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [2:0]  r_funct3;
  logic        r_done;
  logic        r_err;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_accept;
  logic        w_misalign;
  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_accept = io_bus.st_valid && io_bus.st_ready;

  always_comb begin
    w_misalign = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    case (io_bus.st_funct3)
      3'b001:  w_misalign = io_bus.st_addr[0];
      3'b010:  w_misalign = |io_bus.st_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
`else
    w_misalign = 1'b0;
`endif
    w_legal = (io_bus.st_funct3 == 3'b000 || io_bus.st_funct3 == 3'b001 ||
               io_bus.st_funct3 == 3'b010) && !w_misalign;
  end

  // Ack wins over the timeout when both land on the last REQ cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_legal) begin
            w_state_nxt = REQ;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      REQ: begin
        if (io_bus.mem_ack) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_addr   <= 32'd0;
      r_data   <= 32'd0;
      r_funct3 <= 3'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_addr   <= io_bus.st_addr;
        r_data   <= io_bus.st_data;
        r_funct3 <= io_bus.st_funct3;
      end
    end
  end

  // Lane steering from the captured request; misaligned low bits simply fall away.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'd0;
    case (r_funct3)
      3'b000: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_data[7:0]}};
      end
      3'b001: begin
        w_be    = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_data[15:0]}};
      end
      3'b010: begin
        w_be    = 4'b1111;
        w_wdata = r_data;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = 32'd0;
      end
    endcase
  end

  assign io_bus.st_ready  = (r_state == IDLE) && !reset;
  assign io_bus.mem_req   = (r_state == REQ);
  assign io_bus.mem_addr  = {r_addr[31:2], 2'b00};
  assign io_bus.mem_be    = (r_state == REQ) ? w_be : 4'b0000;
  assign io_bus.mem_wdata = (r_state == REQ) ? w_wdata : 32'd0;
  assign io_bus.st_done   = r_done;
  assign io_bus.st_err    = r_err;
  assign o_state          = r_state;

endmodule

// File: tb/tb_store_unit.sv
// Randomized scoreboard bench for store_unit: a lane-steering/outcome model feeds exp_q,
// a negedge monitor pops and compares on every st_done/st_err.
module tb_store_unit;
  localparam int TIMEOUT = 16;
  localparam int EW      = 77;  // {done, req_cycles[7:0], be[3:0], addr[31:0], wdata[31:0]}

  logic clk = 1'b0;
  logic reset;
  logic dbg_state;

  store_unit_if bus ();

  store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset   (reset),
    .io_bus  (bus),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // Monitor-owned tracking
  logic        in_flight = 1'b0;
  int          req_cnt   = 0;
  int          lat       = 0;
  logic        unstable  = 1'b0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference: outcome and memory beat of one store, given the cycle index d of the ack.
  function automatic logic [EW-1:0] model(input logic [31:0] addr, input logic [31:0] data,
                                          input logic [2:0] f3, input int d);
    logic        legal;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          rc;
    legal = 1'b1;
    be    = 4'd0;
    wdata = 32'd0;
    case (f3)
      3'd0: begin
        be    = 4'(1 << (addr % 4));
        wdata = (data & 32'hFF) * 32'h01010101;
      end
      3'd1: begin
        be    = 4'(3 << (2 * ((addr / 2) % 2)));
        wdata = (data & 32'hFFFF) * 32'h00010001;
      end
      3'd2: begin
        be    = 4'hF;
        wdata = data;
      end
      default: legal = 1'b0;
    endcase
`ifdef STORE_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 && addr % 2 != 0) || (f3 == 3'd2 && addr % 4 != 0)) legal = 1'b0;
`endif
    if (!legal) return {1'b0, 8'd0, 4'd0, 32'd0, 32'd0};
    rc = (d < TIMEOUT) ? d + 1 : TIMEOUT;
    return {(d < TIMEOUT) ? 1'b1 : 1'b0, 8'(rc), be, addr & 32'hFFFF_FFFC, wdata};
  endfunction

  task automatic wait_ready(output logic ok);
    int n;
    n = 0;
    while (!bus.st_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    ok = bus.st_ready;
    if (!ok) begin
      failures++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
  endtask

  // Issue one store; ack is raised during REQ cycle d (d >= TIMEOUT means never).
  task automatic issue(input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] f3, input int d, input int gap);
    logic [EW-1:0] e;
    logic          ok;
    int            rc;
    wait_ready(ok);
    if (!ok) return;
    e = model(addr, data, f3, d);
    rc = int'(e[75:68]);
    exp_q.push_back(e);
    bus.mem_ack   = 1'b0;
    bus.st_valid  = 1'b1;
    bus.st_addr   = addr;
    bus.st_data   = data;
    bus.st_funct3 = f3;
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    bus.st_addr  = $urandom;
    bus.st_data  = $urandom;
    for (int n = 0; n < rc; n++) begin
      bus.mem_ack = (n == d);
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    // Acks while idle must be ignored
    repeat (gap) begin
      bus.mem_ack = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_flight = 1'b0;
      req_cnt   = 0;
      unstable  = 1'b0;
    end else begin
      check("done_err_exclusive", {31'd0, bus.st_done && bus.st_err}, 32'd0);
      if (!bus.mem_req) check("idle_be_wdata_zero", {28'd0, bus.mem_be} | bus.mem_wdata, 32'd0);
      if (bus.mem_req) begin
        if (req_cnt == 0) begin
          seen_addr  = bus.mem_addr;
          seen_be    = bus.mem_be;
          seen_wdata = bus.mem_wdata;
        end else if (seen_addr !== bus.mem_addr || seen_be !== bus.mem_be ||
                     seen_wdata !== bus.mem_wdata) begin
          unstable = 1'b1;
        end
        req_cnt++;
      end
      if (in_flight) lat++;
      if (bus.st_done || bus.st_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion actual=done%0d_err%0d expected=none",
                   bus.st_done, bus.st_err);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("outcome", {30'd0, bus.st_done, bus.st_err}, e[76] ? 32'd2 : 32'd1);
          check("req_cycles", 32'(req_cnt), {24'd0, e[75:68]});
          check("latency", 32'(lat), {24'd0, e[75:68]} + 32'd1);
          if (e[75:68] != 8'd0) begin
            check("mem_addr", seen_addr, e[63:32]);
            check("mem_be", {28'd0, seen_be}, {28'd0, e[67:64]});
            check("mem_wdata", seen_wdata, e[31:0]);
            check("payload_stable", {31'd0, unstable}, 32'd0);
          end
        end
        in_flight = 1'b0;
        req_cnt   = 0;
        unstable  = 1'b0;
      end
      if (bus.st_valid && bus.st_ready) begin
        in_flight = 1'b1;
        lat       = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    reset         = 1'b1;
    bus.st_valid  = 1'b0;
    bus.st_addr   = 32'd0;
    bus.st_data   = 32'd0;
    bus.st_funct3 = 3'd0;
    bus.mem_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.st_ready}, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_done_err", {30'd0, bus.st_done, bus.st_err}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {31'd0, bus.st_ready}, 32'd1);

    // Directed cases
    issue(32'h0000_1003, 32'h0000_00A5, 3'd0, 1, 0);
    issue(32'h0000_2002, 32'h1234_BEEF, 3'd1, 0, 0);
    issue(32'h0000_3001, 32'hCAFE_F00D, 3'd2, 0, 1);
    issue(32'h0000_5000, 32'h1111_2222, 3'd2, 1000, 0);
    issue(32'h0000_5004, 32'h3333_4444, 3'd2, TIMEOUT - 1, 0);
    issue(32'h0000_6000, 32'h5555_6666, 3'd3, 0, 2);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [2:0] f3;
      r  = $urandom_range(0, 9);
      f3 = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      issue($urandom, $urandom, f3, $urandom_range(0, 20), $urandom_range(0, 3));
    end

    // Reset while a store is waiting for its ack
    wait_ready(ok);
    if (ok) begin
      bus.st_valid  = 1'b1;
      bus.st_addr   = 32'h0000_4000;
      bus.st_data   = 32'hDEAD_BEEF;
      bus.st_funct3 = 3'd2;
      @(posedge clk); #1;
      bus.st_valid = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("midreq_req_high", {31'd0, bus.mem_req}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("midreq_req_low", {31'd0, bus.mem_req}, 32'd0);
      check("midreq_done_err", {30'd0, bus.st_done, bus.st_err}, 32'd0);
      check("midreq_state", {31'd0, dbg_state}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("midreq_ready", {31'd0, bus.st_ready}, 32'd1);
      check("midreq_no_pulse", {30'd0, bus.st_done, bus.st_err}, 32'd0);
    end
    repeat (TIMEOUT + 4) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of REQ-state cycles without mem_ack before the store aborts (range 2..255).
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port st_valid, input, 1 bit: core presents a store request.
REQ-005 Port st_ready, output, 1 bit: unit can accept a request this cycle.
REQ-006 Port st_addr, input, 32 bits: byte address of the store.
REQ-007 Port st_data, input, 32 bits: store data from the register file, right-aligned.
REQ-008 Port st_funct3, input, 3 bits: 000 SB, 001 SH, 010 SW; other encodings are illegal.
REQ-009 Port st_done, output, 1 bit: one-cycle pulse on store completion.
REQ-010 Port st_err, output, 1 bit: one-cycle pulse when a store is rejected or aborted.
REQ-011 Port mem_req, output, 1 bit: write request to data memory.
REQ-012 Port mem_ack, input, 1 bit: data memory accepted the write.
REQ-013 Port mem_addr, output, 32 bits: word-aligned address, {st_addr[31:2], 2'b00}.
REQ-014 Port mem_wdata, output, 32 bits: lane-replicated write data.
REQ-015 Port mem_be, output, 4 bits: byte enables; bit i enables bits [8i+7:8i].

Function
REQ-016 The FSM SHALL have two states, IDLE and REQ; st_ready = (state==IDLE) && !reset.
REQ-017 A request SHALL be accepted in IDLE on the rising edge where st_valid && st_ready; addr, data, funct3 are captured into registers at that edge.
REQ-018 Lane steering SHALL be: SB: be = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}.
REQ-019 Lane steering SHALL be: SH: be = 4'b0011 << {addr[1],1'b0}, wdata = {2{data[15:0]}}.
REQ-020 Lane steering SHALL be: SW: be = 4'b1111, wdata = data.
REQ-021 A legal accepted request SHALL move the FSM to REQ; mem_req is high from the next cycle and is held, with stable mem_addr, mem_wdata and mem_be, until mem_ack is sampled high.
REQ-022 When mem_ack is sampled high in REQ, the FSM SHALL return to IDLE and st_done SHALL be high for exactly the following cycle.
REQ-023 The earliest next accept SHALL be the cycle after the ack, giving a throughput of one store per two cycles minimum.
REQ-024 An illegal funct3 SHALL produce no mem_req, stay in IDLE, and pulse st_err in the cycle after accept.
REQ-025 An 8-bit counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-026 When the counter reaches TIMEOUT-1 with no ack, the FSM SHALL go to IDLE, drop mem_req, pulse st_err, and not pulse st_done.
REQ-027 An ack on the same cycle as the timeout SHALL take priority: st_done pulses, st_err stays low.
REQ-028 mem_ack sampled in IDLE SHALL be ignored.
REQ-029 mem_be and mem_wdata SHALL be 0 whenever mem_req is 0.
REQ-030 st_done and st_err SHALL never be high together.

Reset
REQ-031 At a clock edge with reset high: state=IDLE, counter=0, captured registers=0, mem_req=0, mem_be=0, mem_wdata=0, mem_addr=0, st_done=0, st_err=0.
REQ-032 Reset in REQ SHALL abandon the store with no st_done and no st_err; mem_req is low from the cycle after the reset edge.

Configuration
REQ-033 With macro STORE_MISALIGN_TRAP_EN defined, SH with addr[0]=1 or SW with addr[1:0]!=0 SHALL be rejected like an illegal funct3 (REQ-024).
REQ-034 Without STORE_MISALIGN_TRAP_EN, misaligned stores SHALL proceed; SH ignores addr[0] and SW ignores addr[1:0], following the steering in REQ-018 to REQ-020.

Verification
REQ-035 SB addr=0x1003 data=0x000000A5, ack 2 cycles after mem_req -> mem_addr=0x1000, be=1000, wdata=0xA5A5A5A5, mem_req held 2 cycles, st_done one pulse.
REQ-036 SH addr=0x2002 data=0x1234BEEF, immediate ack -> be=1100, wdata=0xBEEFBEEF, st_done on the 2nd cycle after accept.
REQ-037 SW addr=0x3001 -> with the macro: st_err pulse, no mem_req; without it: be=1111, mem_addr=0x3000, st_done.
REQ-038 SW, mem_ack held low, TIMEOUT=16 -> mem_req high exactly 16 cycles, then st_err pulse, st_ready high; an ack on that 16th cycle -> st_done instead.
REQ-039 funct3=011 -> st_err pulse, no mem_req; reset asserted mid-REQ -> mem_req low after the edge, no st_done/st_err, st_ready high after reset releases.
